// File: rtl/meter_pkg.sv
`default_nettype none
// ============================================================================
// Module      : meter_pkg
// Description : Shared parking-meter definitions: button channel map,
//               debounce default and the fixed-priority pick helper.
// Revision    : 1.0 - initial release
// ============================================================================
package meter_pkg;

    localparam int N_BTN             = 6;
    localparam int DB_CYCLES_DEFAULT = 3;

    typedef logic [N_BTN-1:0] btn_vec_t;

    typedef enum logic [2:0] {
        BTN_ADD1 = 3'd0,
        BTN_ADD2 = 3'd1,
        BTN_ADD3 = 3'd2,
        BTN_ADD4 = 3'd3,
        BTN_RST1 = 3'd4,
        BTN_RST2 = 3'd5
    } btn_idx_e;

    // Isolates the lowest set bit: channel 0 has the highest priority.
    function automatic btn_vec_t lowest_set(input btn_vec_t req);
        return req & (~req + btn_vec_t'(1));
    endfunction

endpackage
`default_nettype wire

// File: rtl/meter_input_conditioner_if.sv
`default_nettype none
// ============================================================================
// Module      : meter_input_conditioner_if
// Description : Raw button levels in, single-cycle meter command pulses out.
// Revision    : 1.0 - initial release
// ============================================================================
interface meter_input_conditioner_if;
    import meter_pkg::*;

    btn_vec_t btn_raw;
    logic     add1;
    logic     add2;
    logic     add3;
    logic     add4;
    logic     rst1;
    logic     rst2;
    logic     busy;
    logic     drop;

    // master: the conditioner; slave: button panel plus the meter it feeds
    modport master (
        input  btn_raw,
        output add1, add2, add3, add4, rst1, rst2, busy, drop
    );

    modport slave (
        output btn_raw,
        input  add1, add2, add3, add4, rst1, rst2, busy, drop
    );

endinterface
`default_nettype wire

// File: rtl/meter_input_conditioner_debounce.sv
`default_nettype none
// ============================================================================
// Module      : debounce_channel
// Description : Two-flop synchronizer plus counter debouncer for one button;
//               flags the edge on which the debounced level rises.
// Revision    : 1.0 - initial release
// ============================================================================
module debounce_channel #(
    parameter int DB_CYCLES = 3
) (
    input  wire  clk,
    input  wire  rst_n,
    input  wire  btn_raw,
    output logic rise
);

    localparam int CNT_W = $clog2(DB_CYCLES);
    localparam logic [CNT_W-1:0] C_CNT_LAST = CNT_W'(DB_CYCLES - 1);

    logic             r_s1;
    logic             r_sync;
    logic             r_db;
    logic [CNT_W-1:0] r_cnt;
    logic             w_differ;
    logic             w_settled;

    assign w_differ  = (r_sync != r_db);
    assign w_settled = (r_cnt == C_CNT_LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s1   <= 1'b0;
            r_sync <= 1'b0;
            r_db   <= 1'b0;
            r_cnt  <= '0;
        end else begin
            r_s1   <= btn_raw;
            r_sync <= r_s1;
            if (!w_differ) begin
                r_cnt <= '0;
            end else if (w_settled) begin
                r_db  <= r_sync;
                r_cnt <= '0;
            end else begin
                r_cnt <= r_cnt + CNT_W'(1);
            end
        end
    end

    // Coincides with the edge that loads r_db <= 1, so the caller can capture it then.
    assign rise = w_differ & w_settled & r_sync;

endmodule
`default_nettype wire

// File: rtl/meter_input_conditioner.sv
`default_nettype none
// ============================================================================
// Module      : meter_input_conditioner
// Description : Debounces six meter buttons and issues at most one command
//               pulse per clock through a fixed-priority pending queue.
// Revision    : 1.0 - initial release
// ============================================================================
module meter_input_conditioner
    import meter_pkg::*;
#(
    parameter int DB_CYCLES = DB_CYCLES_DEFAULT
) (
    input wire                         clk,
    input wire                         rst_n,
    meter_input_conditioner_if.master  bus
);

    btn_vec_t w_rise;
    btn_vec_t w_grant;
    btn_vec_t w_collide;
    btn_vec_t w_pend_next;
    btn_vec_t r_pending;
    btn_vec_t r_cmd;
    logic     r_drop;

    for (genvar i = 0; i < N_BTN; i++) begin : g_chan
        debounce_channel #(
            .DB_CYCLES (DB_CYCLES)
        ) u_debounce (
            .clk     (clk),
            .rst_n   (rst_n),
            .btn_raw (bus.btn_raw[i]),
            .rise    (w_rise[i])
        );
    end

    // A rise on the channel being granted this edge re-arms it instead of dropping.
    always_comb begin
        w_grant     = lowest_set(r_pending);
        w_collide   = w_rise & r_pending & ~w_grant;
        w_pend_next = (r_pending & ~w_grant) | w_rise;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pending <= '0;
            r_cmd     <= '0;
            r_drop    <= 1'b0;
        end else begin
            r_pending <= w_pend_next;
            r_cmd     <= w_grant;
            r_drop    <= |w_collide;
        end
    end

    assign bus.add1 = r_cmd[BTN_ADD1];
    assign bus.add2 = r_cmd[BTN_ADD2];
    assign bus.add3 = r_cmd[BTN_ADD3];
    assign bus.add4 = r_cmd[BTN_ADD4];
    assign bus.rst1 = r_cmd[BTN_RST1];
    assign bus.rst2 = r_cmd[BTN_RST2];
    assign bus.busy = |r_pending;
    assign bus.drop = r_drop;

endmodule
`default_nettype wire
